fifo_axis_bridge: RTL

- Parametrised bridge from a registered-read FIFO (data valid one cycle after rd_en) to an AXI4-Stream master. Successor to the ad-hoc single-register adaptor between the compression core output FIFO and the output AXIS async FIFO.
- Adds generic data width, a configurable skid buffer so tready may drop at any cycle without loss, tkeep generation on the last beat, and run-time byte-lane reversal.
- Sits in the core_clock domain between the core's output FIFO and the output AXIS async FIFO.

---
 rtl/fifo_axis_bridge_if.sv | 16 +
 rtl/fifo_axis_bridge.sv | 118 +++++++++++
 2 files changed

// File: rtl/fifo_axis_bridge_if.sv
// AXI4-Stream bundle for the fifo_axis_bridge output side.
// The master modport drives data/valid; the slave modport drives tready.
interface fifo_axis_bridge_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/fifo_axis_bridge.sv
// Registered-read FIFO to AXI4-Stream master bridge with skid buffer, tkeep
// generation and byte-lane reversal. Optional counters: FIFO_AXIS_BRIDGE_STATS_EN.
module fifo_axis_bridge #(
    parameter int  DATA_WIDTH = 32,
    parameter int  SKID_DEPTH = 2,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  core_clock,
    input  logic                  bus_reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_last,
    input  logic [KEEP_WIDTH-1:0] fifo_keep,
    input  logic                  rev_endianness,
    fifo_axis_bridge_if.master    m_axis,
    output logic                  busy,
    input  logic                  stats_clear,
    output logic [31:0]           beat_count,
    output logic [31:0]           packet_count
);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [DATA_WIDTH-1:0] data_mem [SKID_DEPTH];
    logic [KEEP_WIDTH-1:0] keep_mem [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] last_mem;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      stored;
    logic                  inflight;
    logic                  out_vld;
    logic                  pop;
    logic [OCC_W-1:0]      projected;
    logic [KEEP_WIDTH-1:0] keep_eff;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [KEEP_WIDTH-1:0] cap_keep;

    function automatic logic [DATA_WIDTH-1:0] reverse_data(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < KEEP_WIDTH; i++)
            r[8*i +: 8] = d[8*(KEEP_WIDTH-1-i) +: 8];
        return r;
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] reverse_keep(input logic [KEEP_WIDTH-1:0] k);
        logic [KEEP_WIDTH-1:0] r;
        for (int i = 0; i < KEEP_WIDTH; i++)
            r[i] = k[KEEP_WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_vld   = (stored != '0);
    assign pop       = out_vld & m_axis.tready;
    assign projected = OCC_W'(stored) + OCC_W'(inflight) - OCC_W'(pop);
    assign fifo_rden = !fifo_empty && !bus_reset && (projected < OCC_W'(SKID_DEPTH));
    assign busy      = out_vld | inflight;

    // A last word with no lanes flagged is taken as a full word
    assign keep_eff = (fifo_last && fifo_keep != '0) ? fifo_keep : '1;
    assign cap_data = rev_endianness ? reverse_data(fifo_data) : fifo_data;
    assign cap_keep = rev_endianness ? reverse_keep(keep_eff) : keep_eff;

    // Stage p1: capture of the word requested by fifo_rden one cycle earlier
    always_ff @(posedge core_clock) begin
        if (bus_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            stored   <= '0;
            inflight <= 1'b0;
        end else begin
            if (inflight)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            stored   <= CNT_W'(projected);
            inflight <= fifo_rden;
        end
    end

    always_ff @(posedge core_clock) begin
        if (inflight && !bus_reset) begin
            data_mem[wr_ptr] <= cap_data;
            keep_mem[wr_ptr] <= cap_keep;
            last_mem[wr_ptr] <= fifo_last;
        end
    end

    // Stage p2: head entry; zeroed while empty so storage needs no reset
    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_vld ? data_mem[rd_ptr] : '0;
    assign m_axis.tkeep  = out_vld ? keep_mem[rd_ptr] : '0;
    assign m_axis.tlast  = out_vld & last_mem[rd_ptr];

`ifdef FIFO_AXIS_BRIDGE_STATS_EN
    always_ff @(posedge core_clock) begin
        if (bus_reset || stats_clear) begin
            beat_count   <= '0;
            packet_count <= '0;
        end else if (pop) begin
            beat_count <= beat_count + 32'd1;
            if (last_mem[rd_ptr])
                packet_count <= packet_count + 32'd1;
        end
    end
`else
    logic unused_stats_clear;
    assign unused_stats_clear = stats_clear;
    assign beat_count         = '0;
    assign packet_count       = '0;
`endif
endmodule
